// File: rtl/mac_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mac_job_sequencer
// Purpose  : Job-level controller that broadcasts a multi-chunk weight to a PE
//            engine and steers each chunk's results into a shift-accumulate adder.
// Revision : 1.0 - initial release
// ============================================================================
module mac_job_sequencer #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 4,
    parameter int RESULT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 3,
    parameter int PE_NUM       = 4,
    parameter int MAX_CHUNKS   = 4,
    parameter int ENG_LAT      = 1,
    parameter int ADD_LAT      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  job_valid,
    output logic                                  job_ready,
    input  logic [MAX_CHUNKS*WEIGHT_WIDTH-1:0]    job_weight,
    input  logic [$clog2(MAX_CHUNKS+1)-1:0]       job_nchunks,
    input  logic [PE_NUM*4*DATA_WIDTH-1:0]        job_data,
    output logic [WEIGHT_WIDTH-1:0]               eng_weight,
    output logic [PE_NUM*4*DATA_WIDTH-1:0]        eng_data,
    input  logic [PE_NUM*RESULT_WIDTH-1:0]        eng_result,
    output logic [PE_NUM*RESULT_WIDTH-1:0]        add_data,
    output logic [SHIFT_WIDTH-1:0]                add_shift,
    output logic                                  add_init,
    input  logic [RESULT_WIDTH-1:0]               add_sum,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [RESULT_WIDTH-1:0]               res_sum,
    output logic                                  busy,
    output logic [15:0]                           jobs_done
);

    localparam int c_NW = $clog2(MAX_CHUNKS + 1);
    localparam int c_CW = $clog2(MAX_CHUNKS + ENG_LAT + ADD_LAT + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_OUT   = 2'd3;

    logic [1:0]                         r_state;
    logic [1:0]                         w_next;
    logic [MAX_CHUNKS*WEIGHT_WIDTH-1:0] r_weight;
    logic [PE_NUM*4*DATA_WIDTH-1:0]     r_data;
    logic [c_NW-1:0]                    r_n;
    logic [c_CW-1:0]                    r_cyc;
    logic [RESULT_WIDTH-1:0]            r_res_sum;
    logic [15:0]                        r_jobs_done;

    logic                               w_job_hs;
    logic                               w_res_hs;
    logic [c_NW-1:0]                    w_nclamp;
    logic                               w_last_issue;
    logic                               w_sample;
    logic                               w_iss_valid;
    logic [SHIFT_WIDTH-1:0]             w_iss_k;
    logic                               w_tag_valid;
    logic [SHIFT_WIDTH-1:0]             w_tag_k;

    assign w_job_hs     = job_valid && (r_state == c_IDLE);
    assign w_res_hs     = res_ready && (r_state == c_OUT);
    assign w_nclamp     = (job_nchunks > c_NW'(MAX_CHUNKS)) ? c_NW'(MAX_CHUNKS) : job_nchunks;
    // r_cyc equals the cycle number counted from the acceptance edge
    assign w_last_issue = (r_cyc == c_CW'(r_n));
    assign w_sample     = (r_cyc == c_CW'(r_n) + c_CW'(ENG_LAT + ADD_LAT));
    assign w_iss_valid  = (r_state == c_ISSUE);
    assign w_iss_k      = SHIFT_WIDTH'(r_cyc - c_CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_job_hs) w_next = (w_nclamp == '0) ? c_OUT : c_ISSUE;
            c_ISSUE: if (w_last_issue) w_next = c_DRAIN;
            c_DRAIN: if (w_sample) w_next = c_OUT;
            c_OUT:   if (w_res_hs) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_weight    <= '0;
            r_data      <= '0;
            r_n         <= '0;
            r_cyc       <= '0;
            r_res_sum   <= '0;
            r_jobs_done <= '0;
        end else begin
            if (w_job_hs) begin
                r_weight <= job_weight;
                r_data   <= job_data;
                r_n      <= w_nclamp;
                r_cyc    <= c_CW'(1);
                if (w_nclamp == '0) r_res_sum <= '0;
            end else if (r_state == c_ISSUE || r_state == c_DRAIN) begin
                r_cyc <= r_cyc + c_CW'(1);
            end
            if (r_state == c_DRAIN && w_sample) r_res_sum <= add_sum;
            if (w_res_hs) r_jobs_done <= r_jobs_done + 16'd1;
        end
    end

    // Chunk index travels alongside the engine so results meet their shift amount
    generate
        if (ENG_LAT == 0) begin : g_tag_comb
            assign w_tag_valid = w_iss_valid;
            assign w_tag_k     = w_iss_k;
        end else begin : g_tag_pipe
            logic                   r_tv [ENG_LAT];
            logic [SHIFT_WIDTH-1:0] r_tk [ENG_LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < ENG_LAT; i++) begin
                        r_tv[i] <= 1'b0;
                        r_tk[i] <= '0;
                    end
                end else begin
                    r_tv[0] <= w_iss_valid;
                    r_tk[0] <= w_iss_k;
                    for (int i = 1; i < ENG_LAT; i++) begin
                        r_tv[i] <= r_tv[i-1];
                        r_tk[i] <= r_tk[i-1];
                    end
                end
            end

            assign w_tag_valid = r_tv[ENG_LAT-1];
            assign w_tag_k     = r_tk[ENG_LAT-1];
        end
    endgenerate

    always_comb begin
        job_ready  = (r_state == c_IDLE);
        busy       = (r_state != c_IDLE);
        res_valid  = (r_state == c_OUT);
        eng_data   = '0;
        eng_weight = '0;
        add_data   = '0;
        add_shift  = '0;
        add_init   = 1'b0;
        if (r_state == c_ISSUE || r_state == c_DRAIN) eng_data = r_data;
        if (r_state == c_ISSUE) begin
            for (int i = 0; i < MAX_CHUNKS; i++) begin
                if (w_iss_k == SHIFT_WIDTH'(i)) eng_weight = r_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
        // Zero inputs with init low leave the adder holding its running sum
        if (w_tag_valid) begin
            add_data  = eng_result;
            add_shift = w_tag_k;
            add_init  = (w_tag_k == '0);
        end
    end

    assign res_sum   = r_res_sum;
    assign jobs_done = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_job_sequencer
// Purpose  : Self-checking bench with engine/adder models and a sum reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_job_sequencer;

    localparam int ENG_LAT = 1;
    localparam int ADD_LAT = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [15:0]  job_weight = '0;
    logic [2:0]   job_nchunks = '0;
    logic [255:0] job_data = '0;
    logic [3:0]   eng_weight;
    logic [255:0] eng_data;
    logic [63:0]  eng_result;
    logic [63:0]  add_data;
    logic [2:0]   add_shift;
    logic         add_init;
    logic [15:0]  add_sum;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [15:0]  res_sum;
    logic         busy;
    logic [15:0]  jobs_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mac_job_sequencer dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_weight(job_weight),
        .job_nchunks(job_nchunks), .job_data(job_data),
        .eng_weight(eng_weight), .eng_data(eng_data), .eng_result(eng_result),
        .add_data(add_data), .add_shift(add_shift), .add_init(add_init), .add_sum(add_sum),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .busy(busy), .jobs_done(jobs_done)
    );

    function automatic logic [63:0] eng_fn(logic [255:0] d, logic [3:0] w);
        logic [63:0] r;
        logic [15:0] a;
        r = '0;
        for (int p = 0; p < 4; p++) begin
            a = '0;
            for (int j = 0; j < 4; j++) a = a + 16'(d[(p*4+j)*16 +: 16] * w);
            r[p*16 +: 16] = a;
        end
        return r;
    endfunction

    function automatic logic [15:0] add_fn(logic [63:0] d, logic [2:0] s);
        logic [31:0] t;
        t = '0;
        for (int p = 0; p < 4; p++) t = t + 32'(d[p*16 +: 16]);
        return 16'(t << (32'(s) * 4));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_result <= '0;
            add_sum    <= '0;
        end else begin
            eng_result <= eng_fn(eng_data, eng_weight);
            add_sum    <= (add_init ? 16'd0 : add_sum) + add_fn(add_data, add_shift);
        end
    end

    // Job result as weighted sum of chunks times the total of all data lanes
    function automatic logic [15:0] ref_sum(logic [15:0] w, int n, logic [255:0] d);
        longint s, acc;
        s = 0;
        acc = 0;
        for (int l = 0; l < 16; l++) s = s + longint'(d[l*16 +: 16]);
        for (int k = 0; k < n; k++) acc = acc + s * longint'(w[k*4 +: 4]) * (longint'(1) << (4*k));
        return 16'(acc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_job(input logic [15:0] w, input logic [2:0] n, input logic [255:0] d,
                           input int hold, input int exp_lat, input logic [15:0] exp_sum);
        int          neff, lat, t, kk;
        bit          seen, bad_acc, bad_ctl, bad_hold, act_k;
        logic [15:0] prev_done;
        logic        exp_init;
        logic [2:0]  exp_shift;
        logic [3:0]  exp_w;
        neff = (n > 3'd4) ? 4 : int'(n);
        t = 0;
        while (!job_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!job_ready) begin
            chk("job_ready_wait", 32'(job_ready), 32'd1);
            return;
        end
        prev_done   = jobs_done;
        job_weight  = w;
        job_nchunks = n;
        job_data    = d;
        job_valid   = 1'b1;
        res_ready   = (hold == 0);
        @(posedge clk);
        seen = 0; lat = 0; bad_acc = 0; bad_ctl = 0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) job_valid = 1'b0;
            kk        = c - 1 - ENG_LAT;
            act_k     = (neff > 0 && kk >= 0 && kk < neff);
            exp_init  = (neff > 0 && kk == 0);
            exp_shift = act_k ? 3'(kk) : 3'd0;
            exp_w     = (c <= neff) ? w[(c-1)*4 +: 4] : 4'd0;
            if (add_init !== exp_init || add_shift !== exp_shift) bad_acc = 1;
            if (!act_k && add_data !== 64'd0) bad_acc = 1;
            if (eng_weight !== exp_w) bad_acc = 1;
            if (job_ready !== 1'b0 || busy !== 1'b1) bad_ctl = 1;
            if (res_valid) begin
                seen = 1;
                lat  = c;
            end
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("res_sum", 32'(res_sum), 32'(exp_sum));
        chk("accum_seq", 32'(bad_acc), 32'd0);
        chk("busy_ready", 32'(bad_ctl), 32'd0);
        if (!seen) begin
            res_ready = 1'b1;
            return;
        end
        bad_hold = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_sum !== exp_sum || job_ready !== 1'b0 || jobs_done !== prev_done)
                bad_hold = 1;
        end
        if (hold > 0) chk("hold_stable", 32'(bad_hold), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("done_inc", 32'(jobs_done), 32'(16'(prev_done + 16'd1)));
        chk("post_idle", 32'({res_valid, job_ready}), 32'b01);
    endtask

    typedef struct {
        logic [15:0] w;
        logic [2:0]  n;
        logic [15:0] dv;
        int          hold;
        int          exp_lat;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [255:0] d;
        logic [15:0]  rw, prev;
        logic [2:0]   rn;
        int           neff, rh, nres;
        bit           bad_res;
        int           acc[$];

        vecs[0] = '{16'h4321, 3'd4, 16'd1, 0, 7, 16'h3210};
        vecs[1] = '{16'h4321, 3'd4, 16'd1, 5, 7, 16'h3210};
        vecs[2] = '{16'h0007, 3'd1, 16'd2, 0, 4, 16'h00E0};
        vecs[3] = '{16'h4321, 3'd0, 16'd1, 0, 1, 16'h0000};
        vecs[4] = '{16'h4321, 3'd7, 16'd1, 0, 7, 16'h3210};
        vecs[5] = '{16'h00FF, 3'd2, 16'd1, 0, 5, 16'h0FF0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 32'({job_ready, busy, res_valid}), 32'b100);
        chk("reset_outs", 32'({eng_weight, |eng_data, |add_data, add_shift, add_init, |res_sum}), 32'd0);
        chk("reset_done", 32'(jobs_done), 32'd0);

        for (int i = 0; i < 6; i++) begin
            for (int l = 0; l < 16; l++) d[l*16 +: 16] = vecs[i].dv;
            run_job(vecs[i].w, vecs[i].n, d, vecs[i].hold, vecs[i].exp_lat, vecs[i].exp_sum);
        end

        // Reset in cycle 3 of an n=4 job
        for (int l = 0; l < 16; l++) d[l*16 +: 16] = 16'd1;
        job_weight = 16'h4321; job_nchunks = 3'd4; job_data = d; job_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ctl", 32'({job_ready, busy, res_valid}), 32'b100);
        chk("midrst_eng", 32'({eng_weight, |eng_data}), 32'd0);
        chk("midrst_add", 32'({|add_data, add_shift, add_init}), 32'd0);
        chk("midrst_done", 32'(jobs_done), 32'd0);
        run_job(16'h0001, 3'd1, d, 0, 4, 16'h0010);

        // Back-to-back with job_valid held
        prev = jobs_done;
        job_weight = 16'h4321; job_nchunks = 3'd4; job_data = d; job_valid = 1'b1;
        res_ready = 1'b1;
        nres = 0; bad_res = 0;
        for (int i = 0; i < 80 && nres < 3; i++) begin
            if (res_valid) begin
                nres++;
                if (res_sum !== 16'h3210) bad_res = 1;
            end
            if (job_valid && job_ready) begin
                acc.push_back(i);
                if (acc.size() == 3) begin
                    @(posedge clk);
                    #1 job_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        job_valid = 1'b0;
        chk("b2b_accepts", 32'(acc.size()), 32'd3);
        if (acc.size() == 3) begin
            chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd8);
            chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd8);
        end
        chk("b2b_results", 32'(nres), 32'd3);
        chk("b2b_sum", 32'(bad_res), 32'd0);
        chk("b2b_done", 32'(jobs_done), 32'(16'(prev + 16'd3)));

        // Randomized jobs against the reference model
        for (int r = 0; r < 20; r++) begin
            rw = 16'($urandom);
            rn = 3'($urandom_range(0, 5));
            rh = int'($urandom_range(0, 2));
            for (int l = 0; l < 16; l++) d[l*16 +: 16] = 16'($urandom);
            neff = (rn > 3'd4) ? 4 : int'(rn);
            run_job(rw, rn, d, rh, (neff == 0) ? 1 : neff + ENG_LAT + ADD_LAT + 1, ref_sum(rw, neff, d));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
